// File: rtl/player_ctrl_if.sv
// Player controller bus: button/hazard inputs in, sprite position and game status out.
// The slave modport is the controller; the master modport is the input source/consumer.
interface player_ctrl_if;
  logic       i_Up;
  logic       i_Dn;
  logic       i_Lt;
  logic       i_Rt;
  logic       i_Collision;
  logic [9:0] o_X;
  logic [9:0] o_Y;
  logic [3:0] o_Level;
  logic [2:0] o_Lives;
  logic       o_Respawning;
  logic       o_Game_Over;
  logic       o_Level_Up;

  modport master (
    output i_Up, i_Dn, i_Lt, i_Rt, i_Collision,
    input  o_X, o_Y, o_Level, o_Lives, o_Respawning, o_Game_Over, o_Level_Up
  );

  modport slave (
    input  i_Up, i_Dn, i_Lt, i_Rt, i_Collision,
    output o_X, o_Y, o_Level, o_Lives, o_Respawning, o_Game_Over, o_Level_Up
  );
endinterface

// File: rtl/player_ctrl.sv
// Grid-stepped player controller with lives, respawn grace, game-over/restart and level-up pulse.
// Moves happen on a move-tick enable derived from a free-running divider in the i_Clk domain.
module player_ctrl #(
  parameter int GAME_WIDTH    = 640,
  parameter int GAME_HEIGHT   = 480,
  parameter int GRID_WIDTH    = 32,
  parameter int GRID_HEIGHT   = 32,
  parameter int PLAYER_WIDTH  = 32,
  parameter int PLAYER_HEIGHT = 32,
  parameter int MOVE_DIV      = 22,
  parameter int MAX_LEVEL     = 9,
  parameter int START_LIVES   = 3,
  parameter int RESPAWN_TICKS = 4
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  player_ctrl_if.slave  bus
);

  localparam logic [9:0]  X0       = 10'((GAME_WIDTH / 2) / GRID_WIDTH * GRID_WIDTH);
  localparam logic [9:0]  Y0       = 10'((GAME_HEIGHT - PLAYER_HEIGHT) / GRID_HEIGHT * GRID_HEIGHT);
  localparam logic [9:0]  GW       = 10'(GRID_WIDTH);
  localparam logic [9:0]  GH       = 10'(GRID_HEIGHT);
  localparam logic [10:0] X_MAX    = 11'(GAME_WIDTH - PLAYER_WIDTH);
  localparam logic [10:0] Y_MAX    = 11'(GAME_HEIGHT - PLAYER_HEIGHT);
  localparam logic [3:0]  LVL_MAX  = 4'(MAX_LEVEL);
  localparam logic [2:0]  LIVES0   = 3'(START_LIVES);
  localparam int          RW       = (RESPAWN_TICKS < 2) ? 1 : $clog2(RESPAWN_TICKS + 1);
  localparam logic [RW-1:0] RESP_LOAD = RW'(RESPAWN_TICKS);

  typedef enum logic [1:0] {PLAY, RESPAWN, GAME_OVER} state_t;

  state_t                state_reg, state_next;
  logic [9:0]            x_reg, x_next;
  logic [9:0]            y_reg, y_next;
  logic [3:0]            level_reg, level_next;
  logic [2:0]            lives_reg, lives_next;
  logic [MOVE_DIV-1:0]   div_reg, div_next;
  logic [RW-1:0]         resp_cnt_reg, resp_cnt_next;
  logic                  level_up_reg, level_up_next;
  logic                  tick;
  logic                  any_btn;

  assign tick    = &div_reg;
  assign any_btn = bus.i_Up | bus.i_Dn | bus.i_Lt | bus.i_Rt;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg    <= PLAY;
      x_reg        <= X0;
      y_reg        <= Y0;
      level_reg    <= 4'd1;
      lives_reg    <= LIVES0;
      div_reg      <= '0;
      resp_cnt_reg <= '0;
      level_up_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      level_reg    <= level_next;
      lives_reg    <= lives_next;
      div_reg      <= div_next;
      resp_cnt_reg <= resp_cnt_next;
      level_up_reg <= level_up_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    level_next    = level_reg;
    lives_next    = lives_reg;
    div_next      = div_reg + MOVE_DIV'(1);
    resp_cnt_next = resp_cnt_reg;
    level_up_next = 1'b0;

    case (state_reg)
      PLAY: begin
        if (bus.i_Collision) begin
          lives_next = lives_reg - 3'd1;
          if (lives_reg == 3'd1) begin
            state_next = GAME_OVER;
          end else begin
            x_next        = X0;
            y_next        = Y0;
            resp_cnt_next = RESP_LOAD;
            state_next    = RESPAWN;
          end
        end else if (y_reg == 10'd0) begin
          x_next        = X0;
          y_next        = Y0;
          level_up_next = 1'b1;
          if (level_reg < LVL_MAX)
            level_next = level_reg + 4'd1;
        end else if (tick) begin
          // Only the highest-priority pressed button is considered; if blocked, the tick is spent.
          if (bus.i_Up) begin
            if (y_reg >= GH) y_next = y_reg - GH;
          end else if (bus.i_Dn) begin
            if ({1'b0, y_reg} + {1'b0, GH} <= Y_MAX) y_next = y_reg + GH;
          end else if (bus.i_Lt) begin
            if (x_reg >= GW) x_next = x_reg - GW;
          end else if (bus.i_Rt) begin
            if ({1'b0, x_reg} + {1'b0, GW} <= X_MAX) x_next = x_reg + GW;
          end
        end
      end
      RESPAWN: begin
        if (tick) begin
          resp_cnt_next = resp_cnt_reg - RW'(1);
          if (resp_cnt_reg <= RW'(1)) begin
            resp_cnt_next = '0;
            state_next    = PLAY;
          end
        end
      end
      GAME_OVER: begin
        if (tick && any_btn) begin
          lives_next = LIVES0;
          level_next = 4'd1;
          x_next     = X0;
          y_next     = Y0;
          state_next = PLAY;
        end
      end
      default: state_next = PLAY;
    endcase
  end

  always_comb begin
    bus.o_X          = x_reg;
    bus.o_Y          = y_reg;
    bus.o_Level      = level_reg;
    bus.o_Lives      = lives_reg;
    bus.o_Level_Up   = level_up_reg;
    bus.o_Respawning = (state_reg == RESPAWN);
    bus.o_Game_Over  = (state_reg == GAME_OVER);
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus random play, checked each cycle against a
// behavioural game model, with literal expectations pinning key points.
module tb_player_ctrl;

  localparam int X0 = 320, Y0 = 448, XMAX = 608, YMAX = 448, GRID = 32;
  localparam int MAXLVL = 9, LIVES0 = 3, GRACE = 4;

  logic clk;
  logic rst_n;
  player_ctrl_if bus();

  player_ctrl #(.MOVE_DIV(2)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 = playing, 1 = respawn grace, 2 = game over
  int m_x, m_y, m_level, m_lives, m_mode, m_grace, m_edges;
  int m_lvlup;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = X0; m_y = Y0; m_level = 1; m_lives = LIVES0;
    m_mode = 0; m_grace = 0; m_edges = 0; m_lvlup = 0;
  endtask

  task automatic model_step();
    bit tick;
    m_edges++;
    tick = (m_edges % 4 == 0);
    m_lvlup = 0;
    if (m_mode == 0) begin
      if (bus.i_Collision) begin
        m_lives--;
        if (m_lives == 0) m_mode = 2;
        else begin
          m_x = X0; m_y = Y0; m_grace = GRACE; m_mode = 1;
        end
      end else if (m_y == 0) begin
        m_x = X0; m_y = Y0; m_lvlup = 1;
        m_level = (m_level + 1 > MAXLVL) ? MAXLVL : m_level + 1;
      end else if (tick) begin
        if (bus.i_Up) begin
          if (m_y - GRID >= 0) m_y -= GRID;
        end else if (bus.i_Dn) begin
          if (m_y + GRID <= YMAX) m_y += GRID;
        end else if (bus.i_Lt) begin
          if (m_x - GRID >= 0) m_x -= GRID;
        end else if (bus.i_Rt) begin
          if (m_x + GRID <= XMAX) m_x += GRID;
        end
      end
    end else if (m_mode == 1) begin
      if (tick) begin
        m_grace--;
        if (m_grace == 0) m_mode = 0;
      end
    end else begin
      if (tick && (bus.i_Up || bus.i_Dn || bus.i_Lt || bus.i_Rt)) begin
        m_lives = LIVES0; m_level = 1; m_x = X0; m_y = Y0; m_mode = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("x", int'(bus.o_X), m_x);
      chk("y", int'(bus.o_Y), m_y);
      chk("level", int'(bus.o_Level), m_level);
      chk("lives", int'(bus.o_Lives), m_lives);
      chk("respawning", int'(bus.o_Respawning), int'(m_mode == 1));
      chk("game_over", int'(bus.o_Game_Over), int'(m_mode == 2));
      chk("level_up", int'(bus.o_Level_Up), m_lvlup);
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input bit u, input bit d, input bit l, input bit r, input bit c);
    bus.i_Up = u; bus.i_Dn = d; bus.i_Lt = l; bus.i_Rt = r; bus.i_Collision = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    clocks(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    clocks(2);
    rst_n = 1'b1;
    #1;
    chk("rst_x", int'(bus.o_X), 320);
    chk("rst_y", int'(bus.o_Y), 448);
    chk("rst_level", int'(bus.o_Level), 1);
    chk("rst_lives", int'(bus.o_Lives), 3);
    chk("rst_resp", int'(bus.o_Respawning), 0);
    chk("rst_go", int'(bus.o_Game_Over), 0);
    chk("rst_lvlup", int'(bus.o_Level_Up), 0);

    // Climb with Up held from reset release
    bus.i_Up = 1'b1;
    clocks(3);  chk("pre_first_tick_y", int'(bus.o_Y), 448);
    clocks(1);  chk("first_tick_y", int'(bus.o_Y), 416);
    clocks(52); chk("top_row_y", int'(bus.o_Y), 0);
    clocks(1);
    chk("lvl2_y", int'(bus.o_Y), 448);
    chk("lvl2_level", int'(bus.o_Level), 2);
    chk("lvl2_pulse", int'(bus.o_Level_Up), 1);
    clocks(1);  chk("lvl2_pulse_end", int'(bus.o_Level_Up), 0);
    clocks(462); chk("level_sat", int'(bus.o_Level), 9);
    chk("climb_y", int'(bus.o_Y), 320);

    // Horizontal limits and single-axis priority
    set_in(0, 0, 1, 0, 0); clocks(48);  chk("left_edge_x", int'(bus.o_X), 0);
    set_in(0, 0, 0, 1, 0); clocks(100); chk("right_edge_x", int'(bus.o_X), 608);
    set_in(1, 0, 1, 0, 0); clocks(12);
    chk("up_lt_x", int'(bus.o_X), 608);
    chk("up_lt_y", int'(bus.o_Y), 224);

    do_reset();
    bus.i_Dn = 1'b1; clocks(12);
    chk("dn_floor_y", int'(bus.o_Y), 448);

    // Collision and respawn grace
    do_reset();
    bus.i_Up = 1'b1; clocks(28);
    chk("coll_pre_y", int'(bus.o_Y), 224);
    set_in(0, 0, 0, 0, 1); clocks(1);
    chk("coll_lives", int'(bus.o_Lives), 2);
    chk("coll_x", int'(bus.o_X), 320);
    chk("coll_y", int'(bus.o_Y), 448);
    chk("coll_resp", int'(bus.o_Respawning), 1);
    for (int i = 0; i < 14; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      clocks(1);
    end
    chk("grace_resp", int'(bus.o_Respawning), 1);
    chk("grace_lives", int'(bus.o_Lives), 2);
    chk("grace_y", int'(bus.o_Y), 448);
    set_in(0, 0, 0, 0, 0); clocks(1);
    chk("grace_end", int'(bus.o_Respawning), 0);

    // Run out of lives, then restart
    set_in(0, 0, 0, 0, 1); clocks(1);
    chk("second_coll_lives", int'(bus.o_Lives), 1);
    set_in(0, 0, 0, 0, 0); clocks(20);
    set_in(0, 0, 0, 1, 0); clocks(4);
    chk("pre_go_x", int'(bus.o_X), 352);
    set_in(0, 0, 0, 0, 1); clocks(1);
    chk("go_flag", int'(bus.o_Game_Over), 1);
    chk("go_lives", int'(bus.o_Lives), 0);
    chk("go_x", int'(bus.o_X), 352);
    set_in(0, 0, 0, 0, 0); clocks(8);
    chk("go_hold", int'(bus.o_Game_Over), 1);
    set_in(0, 0, 0, 1, 0); clocks(4);
    chk("restart_lives", int'(bus.o_Lives), 3);
    chk("restart_level", int'(bus.o_Level), 1);
    chk("restart_x", int'(bus.o_X), 320);
    chk("restart_go", int'(bus.o_Game_Over), 0);

    // Collision coinciding with top-row arrival, then async reset mid-respawn
    do_reset();
    bus.i_Up = 1'b1; clocks(56);
    chk("edge_top_y", int'(bus.o_Y), 0);
    set_in(0, 0, 0, 0, 1); clocks(1);
    chk("edge_lives", int'(bus.o_Lives), 2);
    chk("edge_level", int'(bus.o_Level), 1);
    chk("edge_no_pulse", int'(bus.o_Level_Up), 0);
    set_in(0, 0, 0, 0, 0); clocks(2);
    rst_n = 1'b0;
    #1;
    chk("async_lives", int'(bus.o_Lives), 3);
    chk("async_resp", int'(bus.o_Respawning), 0);
    chk("async_y", int'(bus.o_Y), 448);
    clocks(2);
    rst_n = 1'b1;

    // Random play
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 31) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      clocks(1);
    end
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0);
    clocks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
Grid-stepped player controller for the arcade game, and the successor to the single-level raccoon controller. It is generalised over playfield size, grid pitch, sprite size, move rate, level cap and life count. It adds lives, a respawn grace period, game-over/restart, single-axis move priority and a level-up pulse. It runs entirely in the i_Clk domain with a move-tick enable (no derived clocks), and it feeds the sprite renderer and collision checker.

Parameters:
GAME_WIDTH, 640, playfield width in pixels
GAME_HEIGHT, 480, playfield height in pixels
GRID_WIDTH, 32, horizontal step in pixels
GRID_HEIGHT, 32, vertical step in pixels
PLAYER_WIDTH, 32, sprite width
PLAYER_HEIGHT, 32, sprite height
MOVE_DIV, 22, move tick every 2^MOVE_DIV clocks
MAX_LEVEL, 9, level saturation value (1..15)
START_LIVES, 3, lives after reset/restart (1..7)
RESPAWN_TICKS, 4, move ticks of invulnerability after losing a life

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Up  in  1  move-up button, level-sensitive, synchronised upstream
i_Dn  in  1  move-down button
i_Lt  in  1  move-left button
i_Rt  in  1  move-right button
i_Collision  in  1  hazard overlap, sampled every clock
o_X  out  10  player X position (pixels)
o_Y  out  10  player Y position (pixels)
o_Level  out  4  current level
o_Lives  out  3  remaining lives
o_Respawning  out  1  high while in the RESPAWN state
o_Game_Over  out  1  high while in the GAME_OVER state
o_Level_Up  out  1  one-clock pulse when a level is completed

Behaviour:
- Start position: X0 = (GAME_WIDTH/2)/GRID_WIDTH*GRID_WIDTH and Y0 = (GAME_HEIGHT-PLAYER_HEIGHT)/GRID_HEIGHT*GRID_HEIGHT, using integer division.
- Reset (asynchronous, i_Rst_n=0):
  - o_X=X0, o_Y=Y0, o_Level=1, o_Lives=START_LIVES.
  - o_Respawning=0, o_Game_Over=0, o_Level_Up=0.
  - State=PLAY; divider and respawn counter are cleared.
  - Reset mid-RESPAWN or mid-GAME_OVER returns to exactly these values.
- Tick:
  - A free-running MOVE_DIV-bit counter is used.
  - tick=1 for one clock when the counter equals all-ones, so the first tick falls on clock 2^MOVE_DIV after reset release.
- State PLAY, priority per clock (highest first):
  1. i_Collision=1:
     - Lives decrement.
     - If lives were 1: lives become 0, state goes to GAME_OVER, position is held.
     - Otherwise: position returns to (X0,Y0), respawn counter loads RESPAWN_TICKS, state goes to RESPAWN.
     - A collision beats top-row arrival in the same clock.
  2. o_Y==0:
     - Position returns to (X0,Y0).
     - o_Level increments, saturating at MAX_LEVEL.
     - o_Level_Up=1 for this one clock; state stays PLAY.
     - This fires on the clock after the move that reached row 0. A tick in that clock is ignored.
  3. tick=1:
     - Exactly one axis moves, priority Up > Dn > Lt > Rt. Simultaneous presses never move diagonally.
     - Up: only if o_Y >= GRID_HEIGHT, then o_Y -= GRID_HEIGHT.
     - Dn: only if o_Y + GRID_HEIGHT <= GAME_HEIGHT-PLAYER_HEIGHT, then o_Y += GRID_HEIGHT.
     - Lt: only if o_X >= GRID_WIDTH, then o_X -= GRID_WIDTH.
     - Rt: only if o_X + GRID_WIDTH <= GAME_WIDTH-PLAYER_WIDTH, then o_X += GRID_WIDTH.
     - A blocked highest-priority direction consumes the tick; there is no fallthrough to a lower-priority button.
     - Holding a button repeats the move once per tick.
- State RESPAWN:
  - i_Collision and buttons are ignored.
  - Each tick decrements the counter; on the tick where the counter reaches 0, state goes to PLAY.
  - o_Respawning=1 throughout.
- State GAME_OVER:
  - Position, level and lives (0) are held.
  - On a tick with any button high: lives=START_LIVES, level=1, position (X0,Y0), state goes to PLAY.
- Arithmetic: all position math is 10-bit unsigned. The bounds checks above guarantee no wrap-around.

Test Plan:
- Use MOVE_DIV=2 (tick every 4 clocks) with default geometry, so X0=320 and Y0=448.
- Reset release: o_X=320, o_Y=448, o_Level=1, o_Lives=3, all flags 0. First tick on clock 4.
- Hold i_Up for 14 ticks:
  - o_Y steps 448→416→…→0.
  - Next clock: o_Y=448, o_Level=2, o_Level_Up high for exactly 1 clock.
  - Repeat to level 9; a further completion keeps o_Level=9.
- Boundaries:
  - Hold i_Lt for 12 ticks: o_X reaches 0 after 10 ticks and stays 0.
  - Hold i_Rt: o_X stops at 608.
  - i_Dn at reset: o_Y stays 448.
  - i_Up+i_Lt held together: only o_Y changes.
- Collision at (320,224):
  - o_Lives=2, position (320,448), o_Respawning=1.
  - Collisions and buttons are ignored for 4 ticks, then play resumes.
- Three collisions: o_Lives=0, o_Game_Over=1, position held. i_Rt held for one tick → o_Lives=3, o_Level=1, (320,448), PLAY.
- Edge cases:
  - Collision in the same clock as o_Y==0: life lost, no level-up.
  - i_Rst_n asserted mid-RESPAWN: immediate reset values, no clock edge needed.
